// File: rtl/dmem_access_seq_if.sv
// rtl/dmem_access_seq_if.sv - request, memory and response signal bundle for dmem_access_seq
interface dmem_access_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen_n;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ready, mem_req, mem_addr, mem_wen_n, mem_wdata, rsp_valid, rsp_err, rsp_rdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ready, mem_req, mem_addr, mem_wen_n, mem_wdata, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/dmem_access_seq.sv
// rtl/dmem_access_seq.sv - load/store sequencer splitting word-crossing accesses into two memory transactions
module dmem_access_seq #(
    parameter bit MISALIGN_EN = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    dmem_access_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state, state_nx;
    logic [1:0]  off_q, sz_q;
    logic        sext_q, we_q, err_q, cross_q;
    logic [29:0] base_q;
    logic [31:0] wdata_q, lo_q, hi_q;

    logic [1:0]  req_off, req_sz;
    logic        req_illegal, req_cross, req_err, accept;
    logic [7:0]  size_mask8, mask8;
    logic [63:0] data64, lane64;
    logic [31:0] rd_shift, ld_val;

    // funct3[1:0] encodes the access width directly: 00 byte, 01 half, 10 word
    assign req_off     = bus.req_addr[1:0];
    assign req_sz      = bus.req_funct3[1:0];
    assign req_illegal = (req_sz == 2'b11) ||
                         (bus.req_we ? bus.req_funct3[2] : (bus.req_funct3[2] && req_sz == 2'b10));
    assign req_cross   = (req_sz == 2'b10 && req_off != 2'b00) || (req_sz == 2'b01 && req_off == 2'b11);
    assign req_err     = req_illegal || (req_cross && !MISALIGN_EN);
    assign accept      = (state == IDLE) && bus.req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q   <= 2'b00;
            sz_q    <= 2'b00;
            sext_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cross_q <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            if (accept) begin
                off_q   <= req_off;
                sz_q    <= req_sz;
                sext_q  <= !bus.req_funct3[2];
                we_q    <= bus.req_we;
                err_q   <= req_err;
                cross_q <= req_cross;
                base_q  <= bus.req_addr[31:2];
                wdata_q <= bus.req_wdata;
                hi_q    <= '0;
            end
            if (state == ACC0 && bus.mem_ready) lo_q <= bus.mem_rdata;
            if (state == ACC1 && bus.mem_ready) hi_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.req_valid) state_nx = req_err ? RESP : ACC0;
            ACC0: if (bus.mem_ready) state_nx = cross_q ? ACC1 : RESP;
            ACC1: if (bus.mem_ready) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Store lanes span two words: the low half feeds ACC0, the high half feeds ACC1
    always_comb begin
        case (sz_q)
            2'b00:   size_mask8 = 8'h01;
            2'b01:   size_mask8 = 8'h03;
            default: size_mask8 = 8'h0F;
        endcase
        mask8  = size_mask8 << off_q;
        data64 = {32'b0, wdata_q} << {off_q, 3'b000};
        lane64 = '0;
        for (int i = 0; i < 8; i++) begin
            lane64[8*i +: 8] = mask8[i] ? data64[8*i +: 8] : 8'h00;
        end
    end

    assign rd_shift = 32'({hi_q, lo_q} >> {off_q, 3'b000});

    always_comb begin
        case (sz_q)
            2'b00:   ld_val = sext_q ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'b0, rd_shift[7:0]};
            2'b01:   ld_val = sext_q ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'b0, rd_shift[15:0]};
            default: ld_val = rd_shift;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wen_n = 4'b1111;
        bus.mem_wdata = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            ACC0: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {base_q, 2'b00};
                if (we_q) begin
                    bus.mem_wen_n = ~mask8[3:0];
                    bus.mem_wdata = lane64[31:0];
                end
            end
            ACC1: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {base_q + 30'd1, 2'b00};
                if (we_q) begin
                    bus.mem_wen_n = ~mask8[7:4];
                    bus.mem_wdata = lane64[63:32];
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_rdata = (err_q || we_q) ? 32'h0 : ld_val;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dmem_access_seq.sv
// tb/tb_dmem_access_seq.sv - directed and randomized checks of dmem_access_seq against a byte-level model
module tb_dmem_access_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dmem_access_seq_if bus();
    dmem_access_seq_if bus1();

    dmem_access_seq #(.MISALIGN_EN(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    dmem_access_seq #(.MISALIGN_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int checks = 0;
    int errors = 0;

    bit [31:0] mem [bit [31:0]];
    bit [31:0] t_addr[$];
    bit [3:0]  t_wen[$];
    bit [31:0] t_wdata[$];
    bit [31:0] r_data;
    bit        r_err;
    int        r_lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] rd_word(input bit [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic bit [7:0] rd_byte(input bit [31:0] a);
        bit [31:0] w;
        w = rd_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    // Model works byte by byte: each touched byte picks its word and lane
    task automatic run_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] wdata, input int stall);
        int size, nw, exp_lat, cyc, stall_cnt, idx;
        bit legal, exp_err, got, in_stall;
        bit [31:0] wa[2];
        bit [3:0]  ewen[2];
        bit [31:0] ewd[2];
        bit [31:0] exp_rd, a, w, p_addr, p_wdata, m;
        bit [3:0]  p_wen;

        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nw = 0; exp_rd = 0;
        ewen[0] = 4'hF; ewen[1] = 4'hF; ewd[0] = 0; ewd[1] = 0; wa[0] = 0; wa[1] = 0;
        for (int i = 0; i < size; i++) begin
            a = addr + 32'(i);
            w = {a[31:2], 2'b00};
            if (nw == 0 || wa[nw-1] != w) begin
                wa[nw] = w;
                nw++;
            end
            idx = nw - 1;
            ewen[idx][a[1:0]] = 1'b0;
            ewd[idx][8*a[1:0] +: 8] = wdata[8*i +: 8];
            exp_rd |= 32'(rd_byte(a)) << (8*i);
        end
        if (!f3[2] && size < 4 && exp_rd[8*size-1]) begin
            m = (32'h1 << (8*size)) - 32'h1;
            exp_rd |= ~m;
        end
        exp_err = !legal;
        if (we || exp_err) exp_rd = 0;
        if (!we) begin
            ewen[0] = 4'hF; ewen[1] = 4'hF; ewd[0] = 0; ewd[1] = 0;
        end
        if (exp_err) nw = 0;
        exp_lat = exp_err ? 1 : nw * (stall + 1) + 1;

        t_addr.delete(); t_wen.delete(); t_wdata.delete();
        @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 0;
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        cyc = 1; got = 0; in_stall = 0; stall_cnt = 0;
        p_addr = 0; p_wen = 0; p_wdata = 0;
        while (cyc <= 60 && !got) begin
            if (bus.mem_req) begin
                if (in_stall) begin
                    chk("hold_addr", bus.mem_addr, p_addr);
                    chk("hold_wen", {28'b0, bus.mem_wen_n}, {28'b0, p_wen});
                    chk("hold_wdata", bus.mem_wdata, p_wdata);
                end else begin
                    stall_cnt = stall;
                end
                bus.mem_rdata = rd_word(bus.mem_addr);
                bus.mem_ready = (stall_cnt == 0);
                if (stall_cnt == 0) begin
                    t_addr.push_back(bus.mem_addr);
                    t_wen.push_back(bus.mem_wen_n);
                    t_wdata.push_back(bus.mem_wdata);
                    in_stall = 0;
                end else begin
                    stall_cnt--;
                    in_stall = 1;
                end
                p_addr = bus.mem_addr; p_wen = bus.mem_wen_n; p_wdata = bus.mem_wdata;
            end else begin
                bus.mem_ready = 1'($urandom);
                bus.mem_rdata = $urandom;
                in_stall = 0;
            end
            if (bus.rsp_valid) begin
                got = 1;
                r_data = bus.rsp_rdata; r_err = bus.rsp_err; r_lat = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.mem_ready = 0;
        chk("rsp_seen", {31'b0, got}, 1);
        chk("rsp_latency", r_lat, exp_lat);
        chk("rsp_err", {31'b0, r_err}, {31'b0, exp_err});
        chk("rsp_rdata", r_data, exp_rd);
        chk("mem_txn_count", t_addr.size(), nw);
        for (int k = 0; k < nw; k++) begin
            if (k < t_addr.size()) begin
                chk("txn_addr", t_addr[k], wa[k]);
                chk("txn_wen_n", {28'b0, t_wen[k]}, {28'b0, ewen[k]});
                chk("txn_wdata", t_wdata[k], ewd[k]);
            end
        end
        @(negedge clk);
        chk("rsp_one_cycle", bus.rsp_valid, 0);
        chk("req_ready_after", bus.req_ready, 1);
        if (we && !exp_err) begin
            for (int k = 0; k < nw; k++) begin
                w = rd_word(wa[k]);
                for (int l = 0; l < 4; l++) if (!ewen[k][l]) w[8*l +: 8] = ewd[k][8*l +: 8];
                mem[wa[k]] = w;
            end
        end
    endtask

    initial begin
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
        bus.req_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
        bus1.req_valid = 0; bus1.req_we = 0; bus1.req_funct3 = 0; bus1.req_addr = 0;
        bus1.req_wdata = 0; bus1.mem_ready = 0; bus1.mem_rdata = 0;
        #3 rst_n = 0;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wen_n", {28'b0, bus.mem_wen_n}, 32'hF);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        rst_n = 1;

        mem[32'h100] = 32'hDEADBEEF;
        run_req(0, 3'b010, 32'h100, 0, 0);
        chk("lw_aligned_data", r_data, 32'hDEADBEEF);
        chk("lw_aligned_lat", r_lat, 2);

        mem[32'h100] = 32'h80AABBCC;
        mem[32'h104] = 32'h11223344;
        run_req(0, 3'b101, 32'h103, 0, 0);
        chk("lhu_cross_data", r_data, 32'h00004480);
        run_req(0, 3'b001, 32'h103, 0, 0);
        chk("lh_cross_data", r_data, 32'h00004480);
        chk("lh_cross_lat", r_lat, 3);
        run_req(0, 3'b000, 32'h103, 0, 0);
        chk("lb_data", r_data, 32'hFFFFFF80);

        run_req(1, 3'b010, 32'h102, 32'h11223344, 0);
        chk("sw_acc0_wen", {28'b0, t_wen[0]}, 32'h3);
        chk("sw_acc0_wdata", t_wdata[0], 32'h33440000);
        chk("sw_acc1_addr", t_addr[1], 32'h104);
        chk("sw_acc1_wdata", t_wdata[1], 32'h00001122);

        run_req(1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 0);
        chk("sh_wrap_acc0_addr", t_addr[0], 32'hFFFFFFFC);
        chk("sh_wrap_acc0_wdata", t_wdata[0], 32'hCD000000);
        chk("sh_wrap_acc1_addr", t_addr[1], 32'h00000000);
        chk("sh_wrap_acc1_wen", {28'b0, t_wen[1]}, 32'hE);

        run_req(1, 3'b000, 32'h201, 32'hFFFFFF5A, 3);
        chk("sb_stall_wen", {28'b0, t_wen[0]}, 32'hD);
        chk("sb_stall_wdata", t_wdata[0], 32'h00005A00);
        chk("sb_stall_lat", r_lat, 5);

        run_req(0, 3'b011, 32'h300, 0, 0);
        chk("ld011_err", {31'b0, r_err}, 1);
        run_req(1, 3'b100, 32'h300, 32'h1, 0);
        chk("st100_err", {31'b0, r_err}, 1);

        for (int n = 0; n < 40; n++) begin
            bit [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                             : (32'h400 + 32'($urandom_range(0, 31)));
            run_req(1'($urandom), 3'($urandom), ra, $urandom, $urandom_range(0, 2));
        end

        // Reset pulse while the second half of a crossing load is stalled
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 0; bus.req_funct3 = 3'b001; bus.req_addr = 32'h103;
        bus.mem_ready = 1; bus.mem_rdata = 0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 0;
        @(negedge clk);
        chk("rstmid_acc1_req", bus.mem_req, 1);
        chk("rstmid_acc1_addr", bus.mem_addr, 32'h104);
        bus.mem_ready = 0;
        #2 rst_n = 0;
        #1;
        chk("rstmid_mem_req", bus.mem_req, 0);
        chk("rstmid_req_ready", bus.req_ready, 1);
        chk("rstmid_mem_addr", bus.mem_addr, 0);
        @(negedge clk);
        rst_n = 1;
        bus.mem_ready = 1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("rstmid_no_rsp", bus.rsp_valid, 0);
            chk("rstmid_no_mem", bus.mem_req, 0);
        end
        bus.mem_ready = 0;

        // Misalignment disabled: crossing is an error, non-crossing proceeds normally
        @(negedge clk);
        bus1.req_valid = 1; bus1.req_we = 0; bus1.req_funct3 = 3'b010; bus1.req_addr = 32'h101;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 0;
        chk("noalign_rsp_valid", bus1.rsp_valid, 1);
        chk("noalign_rsp_err", bus1.rsp_err, 1);
        chk("noalign_mem_req", bus1.mem_req, 0);
        @(negedge clk);
        chk("noalign_rsp_done", bus1.rsp_valid, 0);
        bus1.req_valid = 1; bus1.req_funct3 = 3'b001; bus1.req_addr = 32'h102;
        bus1.mem_ready = 1; bus1.mem_rdata = 32'h82345678;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 0;
        chk("noalign_lh_req", bus1.mem_req, 1);
        chk("noalign_lh_addr", bus1.mem_addr, 32'h100);
        @(negedge clk);
        chk("noalign_lh_valid", bus1.rsp_valid, 1);
        chk("noalign_lh_err", bus1.rsp_err, 0);
        chk("noalign_lh_data", bus1.rsp_rdata, 32'hFFFF8234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_access_seq.md
Name: dmem_access_seq

Overview:
- Sequencer between the pipeline load/store stage and the single-ported 32-bit data memory.
- Accepts one byte/half/word load or store per request and issues word-aligned memory transactions with per-byte-lane enables.
- Splits misaligned accesses that cross a word boundary into two back-to-back word transactions.
- Returns the merged, sign- or zero-extended load result or a store completion, with an error flag for illegal encodings.

Parameters:
- MISALIGN_EN, 1: 1 = split word-crossing accesses into two transactions; 0 = report them as errors with no memory traffic.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request valid; held stable until accepted.
- req_ready  out  1  sequencer idle; request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width code: loads 000/001/010/100/101, stores 000/001/010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_req  out  1  memory transaction valid.
- mem_ready  in  1  memory completes the transaction this cycle when mem_req && mem_ready.
- mem_addr  out  32  word address; bits [1:0] are always 00.
- mem_wen_n  out  4  active-low byte-lane write enables; 4'b1111 = no write, including for all reads.
- mem_wdata  out  32  lane-positioned store data.
- mem_rdata  in  32  read word, valid in the completing cycle.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  qualifies rsp_valid: illegal funct3 or disallowed misalignment.
- rsp_rdata  out  32  extended load result; 0 for stores and errors.

Behaviour:
- Reset state: IDLE.
- Reset values: req_ready=1, mem_req=0, mem_addr=0, mem_wen_n=4'b1111, mem_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
- States: IDLE, ACC0, ACC1, RESP.
- req_ready = (state==IDLE).
- On accept, register: off=addr[1:0], size (1/2/4 bytes), sign-extend flag (funct3[2]==0), base=addr&~3.
- Word crossing: off+size>4, i.e. word with off≠0, or half with off=3.
- Illegal funct3 (load 011/110/111; store funct3[2]=1 or 011), or crossing with MISALIGN_EN=0: IDLE -> RESP with rsp_err=1 and no mem_req.
- Store lane mapping: 8-bit mask = size_mask<<off; 64-bit data = wdata<<(8*off).
  - ACC0 uses mask[3:0] and data[31:0].
  - ACC1 uses mask[7:4] and data[63:32].
  - mem_wen_n = ~mask; unused lanes carry 0 data.
- ACC0: mem_req=1, mem_addr=base. Address, data and enables are held stable while mem_ready=0. On mem_ready: capture lo=mem_rdata, then go to ACC1 if crossing, else RESP.
- ACC1: mem_req=1, mem_addr=base+4 modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000. On mem_ready: capture hi=mem_rdata and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Load result: rsp_rdata = ({hi,lo}>>(8*off)), truncated to size, then sign- or zero-extended. hi is treated as 0 when no ACC1 occurs.
  - Store: rsp_rdata=0.
- Latency with mem_ready tied high (accept in cycle 0):
  - aligned or non-crossing: mem_req in cycle 1, rsp_valid in cycle 2;
  - crossing: mem_req in cycles 1-2, rsp_valid in cycle 3.
  - Each cycle of mem_ready=0 adds one cycle.
- No new request is accepted during ACC0, ACC1 or RESP. Back-to-back requests are spaced by at least one IDLE cycle.
- mem_req is never asserted outside ACC0/ACC1. mem_wen_n=4'b1111 whenever mem_req=0 or the access is a load.
- Reset asserted mid-operation: return to IDLE immediately with all outputs at reset values. The aborted request gets no response, and no further mem_req is issued for it.

Test Plan:
- Aligned LW at 0x100, mem_rdata=0xDEADBEEF, mem_ready=1 -> one mem_req at 0x100 with wen_n=1111; cycle 2 rsp_rdata=0xDEADBEEF, rsp_err=0.
- LH at 0x103; word 0x100=0x80AABBCC, word 0x104=0x11223344 -> mem_addr 0x100 then 0x104; rsp_rdata=0x00004480. Same access as LB at 0x103 -> 0xFFFFFF80.
- SW 0x11223344 to 0x102 -> ACC0: wen_n=0011, wdata=0x33440000; ACC1 at 0x104: wen_n=1100, wdata=0x00001122; then rsp_valid with rdata=0.
- SH 0xABCD to 0xFFFFFFFF -> ACC0 at 0xFFFFFFFC with wen_n=0111, wdata=0xCD000000; ACC1 at 0x00000000 with wen_n=1110, wdata=0x000000AB.
- mem_ready low for 3 cycles during an SB to 0x201 -> mem_addr=0x200, wen_n=1101, wdata=0x0000xx00 held stable; rsp_valid exactly 1 cycle after the ready cycle.
- Load funct3=011 -> rsp_err=1 in cycle 1, no mem_req. MISALIGN_EN=0 with LW at 0x101 -> rsp_err=1, no mem_req. rst_n pulsed low during ACC1 -> mem_req drops asynchronously, no rsp_valid follows, req_ready=1.
